// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
// UART transmit frame controller placed directly after the TX serializer.
// It sequences START -> DATA -> [PARITY] -> STOP on TX_OUT, enables the
// serializer during the payload, and reports Busy upstream.
// Every output comes straight from a flop.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits. Without it,
// the controller sends one stop bit.

module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  DATA_VALID,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  frame_abort
);

    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            parEn_q, parEn_d;
    logic            parity_q, parity_d;
    logic [CW-1:0]   timeout_q, timeout_d;
    logic            txOut_q, txOut_d;
    logic            busy_q, busy_d;
    logic            serEn_q, serEn_d;
    logic            abort_q, abort_d;
    logic            accept;
`ifdef UART_TX_TWO_STOP_EN
    logic            stopSecond_q, stopSecond_d;
`endif

    // State, frame settings and all outputs are registered; reset forces the line high at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            parEn_q      <= 1'b0;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            txOut_q      <= 1'b1;
            busy_q       <= 1'b0;
            serEn_q      <= 1'b0;
            abort_q      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stopSecond_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            parEn_q      <= parEn_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            txOut_q      <= txOut_d;
            busy_q       <= busy_d;
            serEn_q      <= serEn_d;
            abort_q      <= abort_d;
`ifdef UART_TX_TWO_STOP_EN
            stopSecond_q <= stopSecond_d;
`endif
        end
    end

    // Next state, request acceptance, timeout, and output values for the upcoming state
    always_comb begin
        state_d   = state_q;
        parEn_d   = parEn_q;
        parity_d  = parity_q;
        timeout_d = '0;
        abort_d   = 1'b0;
        accept    = 1'b0;
        txOut_d   = 1'b1;
        busy_d    = 1'b0;
        serEn_d   = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stopSecond_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    accept = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                // A late ser_done on the final timeout cycle still completes the frame
                if (ser_done) begin
                    state_d = parEn_q ? PARITY : STOP;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    timeout_d = timeout_q + CW'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                if (!stopSecond_q) begin
                    stopSecond_d = 1'b1;
                end else if (DATA_VALID) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                if (DATA_VALID) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The byte itself is held by the serializer; only its parity is kept here
        if (accept) begin
            state_d  = START;
            parEn_d  = PAR_EN;
            parity_d = (^P_DATA) ^ PAR_TYP;
        end

        busy_d  = (state_d != IDLE);
        serEn_d = (state_d == START) || (state_d == DATA);
        case (state_d)
            START:   txOut_d = 1'b0;
            DATA:    txOut_d = ser_data;
            PARITY:  txOut_d = parity_q;
            default: txOut_d = 1'b1;
        endcase
    end

    assign TX_OUT      = txOut_q;
    assign Busy        = busy_q;
    assign ser_en      = serEn_q;
    assign frame_abort = abort_q;

endmodule
